// File: rtl/dp_ram_pkg.sv
// Shared state type, write-mode constants and byte-lane merge helper for dp_ram_be.
// The merge helper works on a fixed maximum width so that any DW up to MAX_DW can use it.
package dp_ram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WR_READ_FIRST  = 0;
   localparam int WR_WRITE_FIRST = 1;

   localparam int MAX_DW = 256;

   // Bit i takes new_w when the enable of its lane (i / bw) is set; we is one bit per lane.
   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_DW-1:0] we,
      input int                bw
   );
      logic [MAX_DW-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_DW; i++) begin
         if (we[i / bw]) begin
            res[i] = new_w[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dp_ram_be_if.sv
// Request/response bundle of dp_ram_be, both ports plus status.
// master issues requests and observes data; slave is the RAM.
interface dp_ram_be_if #(
   parameter int DW    = 32,
   parameter int WORDS = 256,
   parameter int BW    = 8
);
   localparam int NB = DW / BW;
   localparam int AW = $clog2(WORDS);

   logic          init_busy;
   logic          collide;

   logic          en_a;
   logic [AW-1:0] addr_a;
   logic [NB-1:0] we_a;
   logic [DW-1:0] din_a;
   logic [DW-1:0] qout_a;
   logic          vld_a;

   logic          en_b;
   logic [AW-1:0] addr_b;
   logic [NB-1:0] we_b;
   logic [DW-1:0] din_b;
   logic [DW-1:0] qout_b;
   logic          vld_b;

   modport master (
      output en_a, addr_a, we_a, din_a,
      output en_b, addr_b, we_b, din_b,
      input  qout_a, vld_a, qout_b, vld_b,
      input  init_busy, collide
   );

   modport slave (
      input  en_a, addr_a, we_a, din_a,
      input  en_b, addr_b, we_b, din_b,
      output qout_a, vld_a, qout_b, vld_b,
      output init_busy, collide
   );

endinterface

// File: rtl/dp_ram_port.sv
// One RAM port's read register, read-during-write select and valid pulse; latency 1,
// or 2 when DP_RAM_OUT_REG_EN adds an output stage. No backpressure.
module dp_ram_port
   import dp_ram_pkg::*;
#(
   parameter int DW      = 32,
   parameter int WR_MODE = WR_READ_FIRST
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          acc,
   input  logic          wr,
   input  logic [DW-1:0] rd_old,
   input  logic [DW-1:0] rd_new,
   output logic [DW-1:0] qout,
   output logic          vld
);

   logic [DW-1:0] rd_sel;
   logic [DW-1:0] rd_q;
   logic          vld_q;

   // The merged word is only returned when this port itself is writing.
   assign rd_sel = (WR_MODE == WR_WRITE_FIRST && wr) ? rd_new : rd_old;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= acc;
         if (acc) begin
            rd_q <= rd_sel;
         end
      end
   end

`ifdef DP_RAM_OUT_REG_EN
   logic [DW-1:0] out_q;
   logic          out_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         out_vld <= 1'b0;
      end else begin
         out_vld <= vld_q;
         if (vld_q) begin
            out_q <= rd_q;
         end
      end
   end

   assign qout = out_q;
   assign vld  = out_vld;
`else
   assign qout = rd_q;
   assign vld  = vld_q;
`endif

endmodule

// File: rtl/dp_ram_be.sv
// Single-clock true dual-port RAM with byte-lane writes, self-clear after reset and A-over-B lane priority.
// Latency 1, or 2 with DP_RAM_OUT_REG_EN defined; no backpressure, one request per port per cycle.
module dp_ram_be
   import dp_ram_pkg::*;
#(
   parameter int            DW       = 32,
   parameter int            WORDS    = 256,
   parameter int            BW       = 8,
   parameter logic [DW-1:0] INIT_VAL = '0,
   parameter int            WR_MODE  = WR_READ_FIRST
) (
   input logic        clk,
   input logic        rst,
   dp_ram_be_if.slave bus
);

   localparam int NB = DW / BW;
   localparam int AW = $clog2(WORDS);

   if (DW % BW != 0) begin : g_bad_lanes
      $error("dp_ram_be: DW must be a multiple of BW");
   end
   if (DW > MAX_DW) begin : g_bad_width
      $error("dp_ram_be: DW exceeds MAX_DW");
   end
   if (WR_MODE != WR_READ_FIRST && WR_MODE != WR_WRITE_FIRST) begin : g_bad_mode
      $error("dp_ram_be: WR_MODE must be 0 or 1");
   end

   function automatic logic [DW-1:0] merge_w(
      input logic [DW-1:0] old_w,
      input logic [DW-1:0] new_w,
      input logic [NB-1:0] we
   );
      return DW'(byte_merge(MAX_DW'(old_w), MAX_DW'(new_w), MAX_DW'(we), BW));
   endfunction

   logic [DW-1:0] mem [WORDS];

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_nxt;
   logic          clr_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      case (state)
         INIT: begin
            clr_we  = !rst;
            cnt_nxt = cnt + AW'(1);
            if (32'(cnt) == 32'(WORDS - 1)) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   assign bus.init_busy = rst || (state == INIT);

   logic run;
   logic acc_a, acc_b;
   logic inr_a, inr_b;
   logic wr_a, wr_b;

   assign run   = !rst && (state == RUN);
   assign acc_a = run && bus.en_a;
   assign acc_b = run && bus.en_b;
   assign inr_a = 32'(bus.addr_a) < 32'(WORDS);
   assign inr_b = 32'(bus.addr_b) < 32'(WORDS);
   assign wr_a  = acc_a && inr_a && (|bus.we_a);
   assign wr_b  = acc_b && inr_b && (|bus.we_b);

   // new_x is the word at addr_x once this cycle's writes land: B lanes first, A lanes on top.
   logic [DW-1:0] old_a, old_b;
   logic [DW-1:0] new_a, new_b;

   always_comb begin
      old_a = inr_a ? mem[bus.addr_a] : '0;
      old_b = inr_b ? mem[bus.addr_b] : '0;

      new_a = old_a;
      if (wr_b && bus.addr_b == bus.addr_a) begin
         new_a = merge_w(new_a, bus.din_b, bus.we_b);
      end
      if (wr_a) begin
         new_a = merge_w(new_a, bus.din_a, bus.we_a);
      end

      new_b = old_b;
      if (wr_b) begin
         new_b = merge_w(new_b, bus.din_b, bus.we_b);
      end
      if (wr_a && bus.addr_a == bus.addr_b) begin
         new_b = merge_w(new_b, bus.din_a, bus.we_a);
      end
   end

   // On a shared address new_a and new_b are the same fully arbitrated word.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= INIT_VAL;
      end else begin
         if (wr_b) begin
            mem[bus.addr_b] <= new_b;
         end
         if (wr_a) begin
            mem[bus.addr_a] <= new_a;
         end
      end
   end

   logic coll_raw;
   logic coll_q;

   assign coll_raw = acc_a && acc_b && (bus.addr_a == bus.addr_b) &&
                     ((|bus.we_a) || (|bus.we_b));

   always_ff @(posedge clk) begin
      if (rst) begin
         coll_q <= 1'b0;
      end else begin
         coll_q <= coll_raw;
      end
   end

`ifdef DP_RAM_OUT_REG_EN
   logic coll_q2;

   always_ff @(posedge clk) begin
      if (rst) begin
         coll_q2 <= 1'b0;
      end else begin
         coll_q2 <= coll_q;
      end
   end

   assign bus.collide = coll_q2;
`else
   assign bus.collide = coll_q;
`endif

   dp_ram_port #(
      .DW      (DW),
      .WR_MODE (WR_MODE)
   ) u_port_a (
      .clk    (clk),
      .rst    (rst),
      .acc    (acc_a),
      .wr     (wr_a),
      .rd_old (old_a),
      .rd_new (new_a),
      .qout   (bus.qout_a),
      .vld    (bus.vld_a)
   );

   dp_ram_port #(
      .DW      (DW),
      .WR_MODE (WR_MODE)
   ) u_port_b (
      .clk    (clk),
      .rst    (rst),
      .acc    (acc_b),
      .wr     (wr_b),
      .rd_old (old_b),
      .rd_new (new_b),
      .qout   (bus.qout_b),
      .vld    (bus.vld_b)
   );

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench for dp_ram_be: one read-first and one write-first instance driven with identical traffic.
`timescale 1ns/1ps
module tb_dp_ram_be;

   localparam int          DW       = 32;
   localparam int          WORDS    = 16;
   localparam int          BW       = 8;
   localparam int          NB       = DW / BW;
   localparam int          AW       = $clog2(WORDS);
   localparam logic [31:0] INIT_VAL = 32'hDEADBEEF;
`ifdef DP_RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en_a = 1'b0, en_b = 1'b0;
   logic [AW-1:0] addr_a = '0, addr_b = '0;
   logic [NB-1:0] we_a = '0, we_b = '0;
   logic [DW-1:0] din_a = '0, din_b = '0;

   int          cyc   = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          busy  = 0;
   exp_t        exp_q  [2][2][$];
   int          coll_q [2][$];
   logic [31:0] last_q [2][2];
   logic [31:0] model  [WORDS];
   exp_t        mon_e;

   dp_ram_be_if #(.DW(DW), .WORDS(WORDS), .BW(BW)) bus0 ();
   dp_ram_be_if #(.DW(DW), .WORDS(WORDS), .BW(BW)) bus1 ();

   dp_ram_be #(.DW(DW), .WORDS(WORDS), .BW(BW), .INIT_VAL(INIT_VAL), .WR_MODE(0))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   dp_ram_be #(.DW(DW), .WORDS(WORDS), .BW(BW), .INIT_VAL(INIT_VAL), .WR_MODE(1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   assign bus0.en_a = en_a;   assign bus1.en_a = en_a;
   assign bus0.addr_a = addr_a; assign bus1.addr_a = addr_a;
   assign bus0.we_a = we_a;   assign bus1.we_a = we_a;
   assign bus0.din_a = din_a; assign bus1.din_a = din_a;
   assign bus0.en_b = en_b;   assign bus1.en_b = en_b;
   assign bus0.addr_b = addr_b; assign bus1.addr_b = addr_b;
   assign bus0.we_b = we_b;   assign bus1.we_b = we_b;
   assign bus0.din_b = din_b; assign bus1.din_b = din_b;

   logic [31:0] q_w [2][2];
   logic        v_w [2][2];
   logic        c_w [2];
   logic        b_w [2];

   assign q_w[0][0] = bus0.qout_a; assign q_w[0][1] = bus0.qout_b;
   assign q_w[1][0] = bus1.qout_a; assign q_w[1][1] = bus1.qout_b;
   assign v_w[0][0] = bus0.vld_a;  assign v_w[0][1] = bus0.vld_b;
   assign v_w[1][0] = bus1.vld_a;  assign v_w[1][1] = bus1.vld_b;
   assign c_w[0] = bus0.collide;   assign c_w[1] = bus1.collide;
   assign b_w[0] = bus0.init_busy; assign b_w[1] = bus1.init_busy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] lane_wr(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] we);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 4; i++) if (we[i]) mask[8*i +: 8] = 8'hFF;
      return (o & ~mask) | (n & mask);
   endfunction

   // Reference: each request returns the pre-cycle word, except a write-first writer sees the
   // final word; writes apply B lanes then A lanes so A wins on shared lanes.
   task automatic apply_model();
      logic [31:0] nm [WORDS];
      exp_t        e;
      nm = model;
      if (en_b) nm[addr_b] = lane_wr(nm[addr_b], din_b, we_b);
      if (en_a) nm[addr_a] = lane_wr(nm[addr_a], din_a, we_a);
      for (int m = 0; m < 2; m++) begin
         e.due = cyc + LAT;
         if (en_a) begin
            e.data = (m == 1 && we_a != 0) ? nm[addr_a] : model[addr_a];
            exp_q[m][0].push_back(e);
         end
         if (en_b) begin
            e.data = (m == 1 && we_b != 0) ? nm[addr_b] : model[addr_b];
            exp_q[m][1].push_back(e);
         end
         if (en_a && en_b && addr_a == addr_b && (we_a != 0 || we_b != 0))
            coll_q[m].push_back(cyc + LAT);
      end
      model = nm;
   endtask

   task automatic step();
      logic eb;
      logic was_rst;
      #1;
      eb = rst || busy > 0;
      for (int m = 0; m < 2; m++) chk($sformatf("init_busy m%0d", m), b_w[m], eb);
      was_rst = rst;
      if (rst) begin
         busy = WORDS;
         for (int i = 0; i < WORDS; i++) model[i] = INIT_VAL;
         for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++)
               while (exp_q[m][p].size() > 0 && exp_q[m][p][$].due > cyc)
                  void'(exp_q[m][p].pop_back());
            while (coll_q[m].size() > 0 && coll_q[m][$] > cyc) void'(coll_q[m].pop_back());
         end
      end else if (busy > 0) begin
         busy--;
      end else begin
         apply_model();
      end
      @(posedge clk);
      #1;
      if (was_rst) begin
         for (int m = 0; m < 2; m++) for (int p = 0; p < 2; p++) last_q[m][p] = '0;
      end
   endtask

   task automatic set_a(input logic e, input int a, input logic [3:0] w, input logic [31:0] d);
      en_a = e; addr_a = AW'(a); we_a = w; din_a = d;
   endtask

   task automatic set_b(input logic e, input int a, input logic [3:0] w, input logic [31:0] d);
      en_b = e; addr_b = AW'(a); we_b = w; din_b = d;
   endtask

   task automatic rand_req();
      set_a($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, WORDS - 1),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0, $urandom);
      set_b($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, WORDS - 1),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0, $urandom);
   endtask

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         for (int p = 0; p < 2; p++) begin
            if (v_w[m][p]) begin
               if (exp_q[m][p].size() == 0) begin
                  chk($sformatf("vld_unexpected m%0d p%0d", m, p), 32'(v_w[m][p]), 0);
               end else begin
                  mon_e = exp_q[m][p].pop_front();
                  chk($sformatf("latency m%0d p%0d", m, p), cyc, mon_e.due);
                  chk($sformatf("qout m%0d p%0d", m, p), q_w[m][p], mon_e.data);
                  last_q[m][p] = mon_e.data;
               end
            end else begin
               chk($sformatf("qout_hold m%0d p%0d", m, p), q_w[m][p], last_q[m][p]);
               if (exp_q[m][p].size() > 0 && exp_q[m][p][0].due <= cyc) begin
                  chk($sformatf("vld_missing m%0d p%0d", m, p), 32'(v_w[m][p]), 1);
                  void'(exp_q[m][p].pop_front());
               end
            end
         end
         if (c_w[m]) begin
            if (coll_q[m].size() == 0) chk($sformatf("collide_unexpected m%0d", m), 32'(c_w[m]), 0);
            else chk($sformatf("collide_latency m%0d", m), cyc, coll_q[m].pop_front());
         end else if (coll_q[m].size() > 0 && coll_q[m][0] <= cyc) begin
            chk($sformatf("collide_missing m%0d", m), 32'(c_w[m]), 1);
            void'(coll_q[m].pop_front());
         end
      end
   end

   initial begin
      for (int m = 0; m < 2; m++) for (int p = 0; p < 2; p++) last_q[m][p] = '0;
      for (int i = 0; i < WORDS; i++) model[i] = INIT_VAL;
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("reset qout m%0d p%0d", m, p), q_w[m][p], 0);
            chk($sformatf("reset vld m%0d p%0d", m, p), 32'(v_w[m][p]), 0);
         end
         chk($sformatf("reset collide m%0d", m), 32'(c_w[m]), 0);
      end
      step();

      // Clear sequence; a full-word write at clear cycle 2 must be ignored.
      rst = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         if (i == 2) set_a(1, 0, 4'hF, 32'h12345678);
         else set_a(0, 0, 0, 0);
         step();
      end
      set_a(0, 0, 0, 0);

      set_a(1, 0, 4'h0, 0);                 set_b(1, WORDS - 1, 4'h0, 0);          step();
      set_a(1, 3, 4'b0101, 32'h11223344);  set_b(0, 0, 0, 0);                     step();
      set_a(1, 3, 4'h0, 0);                                                        step();
      set_a(1, 5, 4'b0011, 32'hAAAAAAAA);  set_b(1, 5, 4'b1110, 32'hBBBBBBBB);    step();
      set_a(1, 5, 4'h0, 0);                set_b(0, 0, 0, 0);                     step();
      set_a(1, 7, 4'hF, 32'h01020304);     set_b(1, 7, 4'h0, 0);                  step();
      set_a(0, 0, 0, 0);                   set_b(1, 9, 4'b1000, 32'h55000000);    step();
      set_a(1, 7, 4'h0, 0);                set_b(1, 9, 4'h0, 0);                  step();
      set_a(1, 0, 4'h0, 0);                set_b(0, 0, 0, 0);                     step();

      // Random traffic with a one-cycle reset while a read is in flight.
      for (int i = 0; i < 400; i++) begin
         rand_req();
         if (i == 199) set_a(1, 3, 4'h0, 0);
         rst = (i == 200);
         step();
         if (i == 200) begin
            for (int m = 0; m < 2; m++)
               for (int p = 0; p < 2; p++)
                  chk($sformatf("post_rst qout m%0d p%0d", m, p), q_w[m][p], 0);
         end
      end

      rst = 1'b0;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      repeat (4) step();
      for (int m = 0; m < 2; m++) begin
         for (int p = 0; p < 2; p++)
            chk($sformatf("leftover m%0d p%0d", m, p), exp_q[m][p].size(), 0);
         chk($sformatf("leftover_collide m%0d", m), coll_q[m].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
